// File: rtl/pcu_pipe.sv
// Fetch-PC generator: issues PCs over valid/ready, applies trap > mret > branch redirects,
// checks target alignment, halts on ebreak and counts accepted fetches.
module pcu_pipe #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int              ILEN_B   = 4,
  parameter int              CNT_W    = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_fetch_vld,
  input  logic             i_fetch_rdy,
  output logic [XLEN-1:0]  o_pc,
  input  logic             i_redir_vld,
  input  logic [XLEN-1:0]  i_redir_pc,
  input  logic             i_trap,
  input  logic [XLEN-1:0]  i_trap_vec,
  input  logic             i_mret,
  input  logic [XLEN-1:0]  i_mret_pc,
  input  logic             i_halt,
  output logic             o_flush,
  output logic             o_misalign,
  output logic [XLEN-1:0]  o_bad_addr,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  // state    | meaning
  // ST_BOOT  | one idle cycle after reset, no fetch request yet
  // ST_RUN   | issuing PCs, events sampled every cycle
  // ST_HALT  | ebreak seen, fetch stopped until reset
  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  localparam logic [XLEN-1:0]  ILEN_INC = XLEN'(ILEN_B);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             vld_q, vld_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  trap_tgt;
  logic [XLEN-1:0]  jump_tgt;
  logic [XLEN-1:0]  pc_inc;
  logic             jump_req;
  logic             accept;
  logic             unused_trap_lsb;

  assign trap_tgt        = {i_trap_vec[XLEN-1:2], 2'b00};
  assign unused_trap_lsb = ^i_trap_vec[1:0];
  assign jump_req        = i_mret | i_redir_vld;
  assign jump_tgt        = i_mret ? i_mret_pc : i_redir_pc;
  assign pc_inc          = pc_q + ILEN_INC;
  assign accept          = vld_q & i_fetch_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      vld_q      <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      bad_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      vld_q      <= vld_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      bad_addr_q <= bad_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (i_halt && !i_trap) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  // Halt outranks mret/branch; only a trap in the same cycle cancels it.
  always_comb begin
    pc_d       = pc_q;
    vld_d      = vld_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    bad_addr_d = bad_addr_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_BOOT: vld_d = 1'b1;
      ST_RUN: begin
        if (i_trap) begin
          pc_d    = trap_tgt;
          flush_d = 1'b1;
        end else if (i_halt) begin
          pc_d    = pc_inc;
          vld_d   = 1'b0;
          flush_d = 1'b1;
          if (accept) cnt_d = cnt_q + CNT_ONE;
        end else if (jump_req) begin
          flush_d = 1'b1;
          if (jump_tgt[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            bad_addr_d = jump_tgt;
            pc_d       = trap_tgt;
          end else begin
            pc_d = jump_tgt;
          end
        end else if (accept) begin
          pc_d  = pc_inc;
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HALT: vld_d = 1'b0;
      default: vld_d = 1'b0;
    endcase
  end

  assign o_fetch_vld = vld_q;
  assign o_pc        = pc_q;
  assign o_flush     = flush_q;
  assign o_misalign  = misalign_q;
  assign o_bad_addr  = bad_addr_q;
  assign o_halted    = (state_q == ST_HALT);
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pcu_pipe.sv
// Bench for pcu_pipe: directed vector table, a 32-bit/4-bit-counter wrap sequence,
// and randomized traffic checked against a behavioural model.
module tb_pcu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, redir, trap, mret, halt;
  logic [63:0] rpc, tvec, mpc;
  logic        vld, flush, mis, halted;
  logic [63:0] pc, bad, cnt;

  pcu_pipe dut (
    .i_clk(clk), .i_rst(rst), .o_fetch_vld(vld), .i_fetch_rdy(rdy), .o_pc(pc),
    .i_redir_vld(redir), .i_redir_pc(rpc), .i_trap(trap), .i_trap_vec(tvec),
    .i_mret(mret), .i_mret_pc(mpc), .i_halt(halt), .o_flush(flush),
    .o_misalign(mis), .o_bad_addr(bad), .o_halted(halted), .o_fetch_cnt(cnt)
  );

  logic        b_rst, b_rdy;
  logic        b_vld, b_flush, b_mis, b_halted;
  logic [31:0] b_pc, b_bad;
  logic [3:0]  b_cnt;

  pcu_pipe #(.XLEN(32), .RESET_PC(32'hFFFF_FFF0), .ILEN_B(4), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .o_fetch_vld(b_vld), .i_fetch_rdy(b_rdy), .o_pc(b_pc),
    .i_redir_vld(1'b0), .i_redir_pc(32'h0), .i_trap(1'b0), .i_trap_vec(32'h0),
    .i_mret(1'b0), .i_mret_pc(32'h0), .i_halt(1'b0), .o_flush(b_flush),
    .o_misalign(b_mis), .o_bad_addr(b_bad), .o_halted(b_halted), .o_fetch_cnt(b_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rdy, trap;
    logic [63:0] tvec;
    logic        mret;
    logic [63:0] mpc;
    logic        redir;
    logic [63:0] rpc;
    logic        halt;
    logic [63:0] e_pc;
    logic        e_vld, e_flush, e_mis;
    logic [63:0] e_bad;
    logic        e_halted;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: mode 0 boot, 1 run, 2 halted.
  int          m_mode;
  logic [63:0] m_pc, m_bad, m_cnt;
  logic        m_vld, m_flush, m_mis;

  task automatic model_step();
    logic [63:0] tv, t;
    tv = tvec & ~64'd3;
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (rst) begin
      m_mode = 0; m_pc = 64'h8000_0000; m_vld = 1'b0; m_bad = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_vld = 1'b1;
    end else if (m_mode == 1) begin
      if (trap) begin
        m_pc = tv; m_flush = 1'b1;
      end else if (halt) begin
        if (rdy) m_cnt = m_cnt + 1;
        m_pc = m_pc + 4; m_vld = 1'b0; m_flush = 1'b1; m_mode = 2;
      end else if (mret || redir) begin
        t = mret ? mpc : rpc;
        m_flush = 1'b1;
        if (t % 4 != 0) begin
          m_mis = 1'b1; m_bad = t; m_pc = tv;
        end else begin
          m_pc = t;
        end
      end else if (rdy) begin
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic idle_inputs();
    rdy = 0; redir = 0; trap = 0; mret = 0; halt = 0; rpc = 0; tvec = 0; mpc = 0;
  endtask

  initial begin
    rst = 1; b_rst = 1; b_rdy = 0;
    idle_inputs();

    // fields: rst rdy trap tvec mret mpc redir rpc halt | pc vld flush mis bad halted cnt
    vecs.push_back('{1,1,0,0,0,0,0,0,0, 64'h8000_0000,0,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0000,1,0,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0004,1,0,0,0,0,1});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0008,1,0,0,0,0,2});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_000C,1,0,0,0,0,3});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0010,1,0,0,0,0,4});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 64'h8000_0010,1,0,0,0,0,4});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 64'h8000_0010,1,0,0,0,0,4});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 64'h8000_0010,1,0,0,0,0,4});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0014,1,0,0,0,0,5});
    vecs.push_back('{0,0,1,64'h8000_0203,0,0,1,64'h8000_0100,0, 64'h8000_0200,1,1,0,0,0,5});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0204,1,0,0,0,0,6});
    vecs.push_back('{0,1,0,64'h8000_0203,1,64'h8000_0102,0,0,0, 64'h8000_0200,1,1,1,64'h8000_0102,0,6});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h8000_0204,1,0,0,64'h8000_0102,0,7});
    vecs.push_back('{0,1,0,0,0,0,1,64'h8000_0400,0, 64'h8000_0400,1,1,0,64'h8000_0102,0,7});
    vecs.push_back('{0,0,0,0,0,0,0,0,1, 64'h8000_0404,0,1,0,64'h8000_0102,1,7});
    vecs.push_back('{0,1,1,64'h9000_0000,1,64'h600,1,64'h500,0, 64'h8000_0404,0,0,0,64'h8000_0102,1,7});
    vecs.push_back('{1,0,0,0,0,0,0,0,0, 64'h8000_0000,0,0,0,0,0,0});
    vecs.push_back('{0,0,0,0,0,0,0,0,0, 64'h8000_0000,1,0,0,0,0,0});
    vecs.push_back('{0,1,1,64'h1001,0,0,0,0,1, 64'h1000,1,1,0,0,0,0});
    vecs.push_back('{0,1,0,0,0,0,0,0,0, 64'h1004,1,0,0,0,0,1});
    vecs.push_back('{0,1,0,64'h3000,0,0,1,64'h2002,0, 64'h3000,1,1,1,64'h2002,0,1});
    vecs.push_back('{0,0,0,0,1,64'h4000,1,64'h5000,0, 64'h4000,1,1,0,64'h2002,0,1});
    vecs.push_back('{0,1,0,0,0,0,0,0,1, 64'h4004,0,1,0,64'h2002,1,2});

    // 32-bit instance: PC wrap and 4-bit counter wrap
    @(posedge clk); #1;
    b_rst = 0; b_rdy = 1;
    @(posedge clk); #1;
    chk("b_first_pc", 64'(b_pc), 64'hFFFF_FFF0);
    chk("b_first_vld", 64'(b_vld), 64'd1);
    repeat (4) begin @(posedge clk); #1; end
    chk("b_pc_wrap", 64'(b_pc), 64'h0);
    chk("b_cnt_4", 64'(b_cnt), 64'd4);
    repeat (12) begin @(posedge clk); #1; end
    chk("b_cnt_wrap", 64'(b_cnt), 64'd0);
    chk("b_pc_after16", 64'(b_pc), 64'h30);
    chk("b_flags", {60'd0, b_flush, b_mis, b_halted, 1'b0}, 64'd0);
    chk("b_bad", 64'(b_bad), 64'd0);
    b_rdy = 0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; rdy = vecs[i].rdy; trap = vecs[i].trap; tvec = vecs[i].tvec;
      mret = vecs[i].mret; mpc = vecs[i].mpc; redir = vecs[i].redir; rpc = vecs[i].rpc;
      halt = vecs[i].halt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d_vld", i), 64'(vld), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_flush", i), 64'(flush), 64'(vecs[i].e_flush));
      chk($sformatf("v%0d_misalign", i), 64'(mis), 64'(vecs[i].e_mis));
      chk($sformatf("v%0d_bad_addr", i), bad, vecs[i].e_bad);
      chk($sformatf("v%0d_halted", i), 64'(halted), 64'(vecs[i].e_halted));
      chk($sformatf("v%0d_cnt", i), cnt, vecs[i].e_cnt);
    end

    for (int n = 0; n < 2000; n++) begin
      rst   = (n == 0) || ($urandom_range(0, 59) == 0);
      rdy   = ($urandom_range(0, 9) < 7);
      trap  = ($urandom_range(0, 15) == 0);
      mret  = ($urandom_range(0, 9) == 0);
      redir = ($urandom_range(0, 7) == 0);
      halt  = ($urandom_range(0, 79) == 0);
      tvec  = {$urandom, $urandom};
      mpc   = {$urandom, $urandom};
      rpc   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) mpc[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      model_step();
      @(posedge clk); #1;
      chk($sformatf("r%0d_pc", n), pc, m_pc);
      chk($sformatf("r%0d_vld", n), 64'(vld), 64'(m_vld));
      chk($sformatf("r%0d_flush", n), 64'(flush), 64'(m_flush));
      chk($sformatf("r%0d_misalign", n), 64'(mis), 64'(m_mis));
      chk($sformatf("r%0d_bad_addr", n), bad, m_bad);
      chk($sformatf("r%0d_halted", n), 64'(halted), 64'(m_mode == 2));
      chk($sformatf("r%0d_cnt", n), cnt, m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
